// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op codes, FSM states,
// the EX result-mux select code and small op-decode helpers.
package ex_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // EX result mux select for the multiply/divide result
    localparam logic [2:0] ALUSEL_MD = 3'b111;

    localparam logic STEP_MUL = 1'b0;
    localparam logic STEP_DIV = 1'b1;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic rs1_signed(input logic [2:0] op);
        logic res;
        case (op)
            MD_MULH, MD_MULHSU, MD_DIV, MD_REM: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic rs2_signed(input logic [2:0] op);
        logic res;
        case (op)
            MD_MULH, MD_DIV, MD_REM: res = 1'b1;
            default:                 res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the ID/EX latch, pipeline control and the
// multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
);
    logic                 start_i;
    logic [2:0]           mdop_i;
    logic [XLEN-1:0]      reg1_i;
    logic [XLEN-1:0]      reg2_i;
    logic [REGADDR_W-1:0] wd_i;
    logic                 flush_i;
    logic                 stall_o;
    logic                 done_o;
    logic [REGADDR_W-1:0] wd_o;
    logic                 wreg_o;
    logic [XLEN-1:0]      wdata_o;

    modport master (
        output start_i, mdop_i, reg1_i, reg2_i, wd_i, flush_i,
        input  stall_o, done_o, wd_o, wreg_o, wdata_o
    );

    modport slave (
        input  start_i, mdop_i, reg1_i, reg2_i, wd_i, flush_i,
        output stall_o, done_o, wd_o, wreg_o, wdata_o
    );
endinterface

// File: rtl/ex_muldiv_unit_md_iter_step.sv
// One radix-2 iteration on the {hi,lo} accumulator: shift-add for multiply,
// restoring shift-subtract for divide (hi = partial remainder, lo = quotient).
module md_iter_step
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              mode,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN-1:0] hi_s;
    logic [XLEN-1:0] lo_s;
    logic [XLEN:0]   sum_s;
    logic [XLEN:0]   shl_s;
    logic [XLEN:0]   diff_s;

    assign hi_s   = acc_in[2*XLEN-1:XLEN];
    assign lo_s   = acc_in[XLEN-1:0];
    assign sum_s  = {1'b0, hi_s} + (lo_s[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    assign shl_s  = {hi_s, lo_s[XLEN-1]};
    assign diff_s = shl_s - {1'b0, opnd};

    // Select the step result; diff_s MSB set means the trial subtract borrowed
    always_comb begin
        acc_out = {(2*XLEN){1'b0}};
        if (mode == STEP_MUL) begin
            acc_out = {sum_s, lo_s[XLEN-1:1]};
        end else if (diff_s[XLEN]) begin
            acc_out = {shl_s[XLEN-1:0], lo_s[XLEN-2:0], 1'b0};
        end else begin
            acc_out = {diff_s[XLEN-1:0], lo_s[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: UNROLL radix-2 steps
// per clock on operand magnitudes, sign fixup at the end, stall until done.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int UNROLL    = 1,
    parameter int REGADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    ex_muldiv_unit_if.slave  md
);

    localparam int N     = XLEN / UNROLL;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    md_state_e            state_r;
    md_state_e            state_nxt_s;
    logic [2:0]           op_r;
    logic [REGADDR_W-1:0] wd_r;
    logic                 wreg_r;
    logic [2*XLEN-1:0]    acc_r;
    logic [XLEN-1:0]      opnd_r;
    logic                 neg_q_r;
    logic                 neg_r_r;
    logic [XLEN-1:0]      result_r;
    logic [CNT_W-1:0]     cnt_r;

    logic                 sign1_s;
    logic                 sign2_s;
    logic [XLEN-1:0]      mag1_s;
    logic [XLEN-1:0]      mag2_s;
    logic                 div_zero_s;
    logic                 ovf_s;
    logic                 fast_s;
    logic [XLEN-1:0]      fast_res_s;
    logic [2*XLEN-1:0]    acc_fin_s;
    logic [2*XLEN-1:0]    prod_s;
    logic [XLEN-1:0]      quo_s;
    logic [XLEN-1:0]      rem_s;
    logic [XLEN-1:0]      final_res_s;
    logic [2*XLEN-1:0]    acc_chain_s [UNROLL+1];

    assign acc_chain_s[0] = acc_r;

    genvar gi;
    generate
        for (gi = 0; gi < UNROLL; gi++) begin : g_step
            md_iter_step #(.XLEN(XLEN)) u_step (
                .mode    (op_is_div(op_r) ? STEP_DIV : STEP_MUL),
                .acc_in  (acc_chain_s[gi]),
                .opnd    (opnd_r),
                .acc_out (acc_chain_s[gi+1])
            );
        end
    endgenerate

    assign acc_fin_s = acc_chain_s[UNROLL];

    // Decode the incoming op: operand magnitudes and the single-cycle special cases
    always_comb begin
        sign1_s    = rs1_signed(md.mdop_i) & md.reg1_i[XLEN-1];
        sign2_s    = rs2_signed(md.mdop_i) & md.reg2_i[XLEN-1];
        mag1_s     = sign1_s ? ({XLEN{1'b0}} - md.reg1_i) : md.reg1_i;
        mag2_s     = sign2_s ? ({XLEN{1'b0}} - md.reg2_i) : md.reg2_i;
        div_zero_s = op_is_div(md.mdop_i) & (md.reg2_i == {XLEN{1'b0}});
        ovf_s      = ((md.mdop_i == MD_DIV) || (md.mdop_i == MD_REM)) &&
                     (md.reg1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (md.reg2_i == {XLEN{1'b1}});
        fast_s     = (md.wd_i == {REGADDR_W{1'b0}}) | div_zero_s | ovf_s;
        fast_res_s = {XLEN{1'b0}};
        // bit 1 of a divide op distinguishes REM/REMU from DIV/DIVU
        if (md.wd_i == {REGADDR_W{1'b0}}) begin
            fast_res_s = {XLEN{1'b0}};
        end else if (div_zero_s) begin
            fast_res_s = md.mdop_i[1] ? md.reg1_i : {XLEN{1'b1}};
        end else if (ovf_s) begin
            fast_res_s = md.mdop_i[1] ? {XLEN{1'b0}} : md.reg1_i;
        end else begin
            fast_res_s = {XLEN{1'b0}};
        end
    end

    // Sign fixup of the final accumulator and result selection
    always_comb begin
        prod_s = neg_q_r ? ({(2*XLEN){1'b0}} - acc_fin_s) : acc_fin_s;
        quo_s  = neg_q_r ? ({XLEN{1'b0}} - acc_fin_s[XLEN-1:0]) : acc_fin_s[XLEN-1:0];
        rem_s  = neg_r_r ? ({XLEN{1'b0}} - acc_fin_s[2*XLEN-1:XLEN])
                         : acc_fin_s[2*XLEN-1:XLEN];
        case (op_r)
            MD_MUL:                       final_res_s = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: final_res_s = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              final_res_s = quo_s;
            MD_REM, MD_REMU:              final_res_s = rem_s;
            default:                      final_res_s = {XLEN{1'b0}};
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MD_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush squashes everything including a same-cycle start
    always_comb begin
        state_nxt_s = state_r;
        if (md.flush_i) begin
            state_nxt_s = MD_IDLE;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (md.start_i) begin
                        state_nxt_s = fast_s ? MD_DONE : MD_CALC;
                    end else begin
                        state_nxt_s = MD_IDLE;
                    end
                end
                MD_CALC: begin
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = MD_DONE;
                    end else begin
                        state_nxt_s = MD_CALC;
                    end
                end
                MD_DONE: state_nxt_s = MD_IDLE;
                default: state_nxt_s = MD_IDLE;
            endcase
        end
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (rst || md.flush_i) begin
            op_r     <= 3'd0;
            wd_r     <= {REGADDR_W{1'b0}};
            wreg_r   <= 1'b0;
            acc_r    <= {(2*XLEN){1'b0}};
            opnd_r   <= {XLEN{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            result_r <= {XLEN{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (md.start_i) begin
                        op_r     <= md.mdop_i;
                        wd_r     <= md.wd_i;
                        wreg_r   <= (md.wd_i != {REGADDR_W{1'b0}});
                        neg_q_r  <= sign1_s ^ sign2_s;
                        neg_r_r  <= sign1_s;
                        result_r <= fast_res_s;
                        cnt_r    <= {CNT_W{1'b0}};
                        // multiply keeps the multiplier in lo, divide keeps the dividend
                        if (op_is_div(md.mdop_i)) begin
                            acc_r  <= {{XLEN{1'b0}}, mag1_s};
                            opnd_r <= mag2_s;
                        end else begin
                            acc_r  <= {{XLEN{1'b0}}, mag2_s};
                            opnd_r <= mag1_s;
                        end
                    end
                end
                MD_CALC: begin
                    acc_r <= acc_fin_s;
                    if (cnt_r == CNT_LAST) begin
                        cnt_r    <= {CNT_W{1'b0}};
                        result_r <= final_res_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                MD_DONE: begin
                    wd_r     <= {REGADDR_W{1'b0}};
                    wreg_r   <= 1'b0;
                    result_r <= {XLEN{1'b0}};
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Outputs: stall while accepting or iterating, result only in the DONE cycle
    always_comb begin
        md.stall_o = (md.start_i & (state_r == MD_IDLE)) | (state_r == MD_CALC);
        if (state_r == MD_DONE) begin
            md.done_o  = 1'b1;
            md.wd_o    = wd_r;
            md.wreg_o  = wreg_r;
            md.wdata_o = result_r;
        end else begin
            md.done_o  = 1'b0;
            md.wd_o    = {REGADDR_W{1'b0}};
            md.wreg_o  = 1'b0;
            md.wdata_o = {XLEN{1'b0}};
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: a vector table run on UNROLL=1 and UNROLL=4
// instances, plus flush, mid-op reset and back-to-back sequences.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sel;
    logic        flush;
    logic [2:0]  mdop;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.XLEN(32), .REGADDR_W(5)) if1 ();
    ex_muldiv_unit_if #(.XLEN(32), .REGADDR_W(5)) if4 ();

    assign if1.start_i = start & ~sel;
    assign if1.mdop_i  = mdop;
    assign if1.reg1_i  = reg1;
    assign if1.reg2_i  = reg2;
    assign if1.wd_i    = wd;
    assign if1.flush_i = flush;
    assign if4.start_i = start & sel;
    assign if4.mdop_i  = mdop;
    assign if4.reg1_i  = reg1;
    assign if4.reg2_i  = reg2;
    assign if4.wd_i    = wd;
    assign if4.flush_i = flush;

    ex_muldiv_unit #(.XLEN(32), .UNROLL(1), .REGADDR_W(5)) u_dut1 (
        .clk (clk), .rst (rst), .md (if1)
    );
    ex_muldiv_unit #(.XLEN(32), .UNROLL(4), .REGADDR_W(5)) u_dut4 (
        .clk (clk), .rst (rst), .md (if4)
    );

    logic        done_s, stall_s, wreg_s;
    logic [4:0]  wdo_s;
    logic [31:0] wdata_s;
    assign done_s  = sel ? if4.done_o  : if1.done_o;
    assign stall_s = sel ? if4.stall_o : if1.stall_o;
    assign wreg_s  = sel ? if4.wreg_o  : if1.wreg_o;
    assign wdo_s   = sel ? if4.wd_o    : if1.wd_o;
    assign wdata_s = sel ? if4.wdata_o : if1.wdata_o;

    typedef struct {
        logic        sel;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wd;
        logic [31:0] exp_data;
        logic        exp_wreg;
        int          exp_lat;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int          cyc;
        int          stalls;
        bit          got;
        logic [31:0] d;
        logic [4:0]  w;
        logic        wr;
        sel = v.sel; mdop = v.op; reg1 = v.a; reg2 = v.b; wd = v.wd; start = 1'b1;
        #1;
        cyc = 0; got = 1'b0; d = 32'd0; w = 5'd0; wr = 1'b0;
        stalls = stall_s ? 1 : 0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (stall_s) stalls++;
            if (done_s) begin
                got = 1'b1; d = wdata_s; w = wdo_s; wr = wreg_s;
                start = 1'b0;
            end else begin
                reg1 = $urandom; reg2 = $urandom;
            end
        end
        chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.exp_lat));
        chk($sformatf("v%0d_wdata", idx), d, v.exp_data);
        chk($sformatf("v%0d_wd", idx), {27'd0, w}, v.exp_wreg ? {27'd0, v.wd} : 32'd0);
        chk($sformatf("v%0d_wreg", idx), {31'd0, wr}, {31'd0, v.exp_wreg});
        chk($sformatf("v%0d_stalls", idx), 32'(stalls), 32'(v.exp_lat));
        @(negedge clk);
        chk($sformatf("v%0d_done_after", idx), {31'd0, done_s}, 32'd0);
    endtask

    initial begin
        int  spurious;
        int  ndone;
        vec_t m;

        vecs[0]  = '{1'b0, MD_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b1, 33};
        vecs[1]  = '{1'b0, MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 1'b1, 33};
        vecs[2]  = '{1'b0, MD_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd2,  32'hFFFFFFFF, 1'b1, 33};
        vecs[3]  = '{1'b0, MD_MULH,   32'h80000000, 32'h80000000, 5'd3,  32'h40000000, 1'b1, 33};
        vecs[4]  = '{1'b0, MD_DIVU,   32'd100,      32'd0,        5'd4,  32'hFFFFFFFF, 1'b1, 1};
        vecs[5]  = '{1'b0, MD_REMU,   32'd100,      32'd0,        5'd6,  32'd100,      1'b1, 1};
        vecs[6]  = '{1'b0, MD_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h80000000, 1'b1, 1};
        vecs[7]  = '{1'b0, MD_REM,    32'h80000000, 32'hFFFFFFFF, 5'd8,  32'd0,        1'b1, 1};
        vecs[8]  = '{1'b0, MD_DIV,    32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFD, 1'b1, 33};
        vecs[9]  = '{1'b0, MD_REM,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFF, 1'b1, 33};
        vecs[10] = '{1'b0, MD_DIVU,   32'hFFFFFFF9, 32'd2,        5'd11, 32'h7FFFFFFC, 1'b1, 33};
        vecs[11] = '{1'b0, MD_MUL,    32'd3,        32'd4,        5'd0,  32'd0,        1'b0, 1};
        vecs[12] = '{1'b1, MD_MUL,    32'd12345,    32'd678,      5'd12, 32'h007FB6F6, 1'b1, 9};
        vecs[13] = '{1'b1, MD_DIV,    32'hFFFFFF9C, 32'd7,        5'd13, 32'hFFFFFFF2, 1'b1, 9};
        vecs[14] = '{1'b1, MD_REM,    32'hFFFFFF9C, 32'd7,        5'd14, 32'hFFFFFFFE, 1'b1, 9};
        vecs[15] = '{1'b0, MD_DIV,    32'h12345678, 32'd0,        5'd15, 32'hFFFFFFFF, 1'b1, 1};
        vecs[16] = '{1'b0, MD_MULH,   32'hFFFFFFFF, 32'd5,        5'd16, 32'hFFFFFFFF, 1'b1, 33};
        vecs[17] = '{1'b1, MD_MULHU,  32'h00010000, 32'h00010000, 5'd17, 32'd1,        1'b1, 9};

        rst = 1'b1; start = 1'b0; sel = 1'b0; flush = 1'b0;
        mdop = 3'd0; reg1 = 32'd0; reg2 = 32'd0; wd = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_done1",  {31'd0, if1.done_o},  32'd0);
        chk("rst_stall1", {31'd0, if1.stall_o}, 32'd0);
        chk("rst_wreg1",  {31'd0, if1.wreg_o},  32'd0);
        chk("rst_wdata1", if1.wdata_o,          32'd0);
        chk("rst_done4",  {31'd0, if4.done_o},  32'd0);
        chk("rst_wd4",    {27'd0, if4.wd_o},    32'd0);

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i], i);
        end

        // Flush of an in-flight DIV at cycle 10, new MUL started at cycle 11
        sel = 1'b0; mdop = MD_DIV; reg1 = 32'd1000; reg2 = 32'd7; wd = 5'd3; start = 1'b1;
        spurious = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done_s) spurious++;
        end
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_spurious", 32'(spurious), 32'd0);
        chk("flush_stall",    {31'd0, stall_s}, 32'd0);
        chk("flush_done",     {31'd0, done_s},  32'd0);
        m = '{1'b0, MD_MUL, 32'h00001234, 32'h00000010, 5'd20, 32'h00012340, 1'b1, 33};
        run_op(m, 100);

        // Reset at cycle 5 of a DIVU
        sel = 1'b0; mdop = MD_DIVU; reg1 = 32'd5000; reg2 = 32'd3; wd = 5'd4; start = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_stall", {31'd0, stall_s}, 32'd0);
        chk("rst_mid_done",  {31'd0, done_s},  32'd0);
        chk("rst_mid_wdata", wdata_s,          32'd0);
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_s) spurious++;
        end
        chk("rst_mid_spurious", 32'(spurious), 32'd0);

        // Back-to-back on UNROLL=4 with start held across both instructions
        sel = 1'b1; mdop = MD_MUL; reg1 = 32'd12345; reg2 = 32'd678; wd = 5'd7; start = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done_s) begin
                ndone++;
                if (ndone == 1) begin
                    chk("b2b_first_cycle", 32'(c), 32'd9);
                    chk("b2b_first_data",  wdata_s, 32'h007FB6F6);
                    mdop = MD_DIVU; reg1 = 32'd100; reg2 = 32'd7; wd = 5'd8;
                end else if (ndone == 2) begin
                    chk("b2b_second_cycle", 32'(c), 32'd19);
                    chk("b2b_second_data",  wdata_s, 32'd14);
                    chk("b2b_second_wd",    {27'd0, wdo_s}, 32'd8);
                    start = 1'b0;
                end
            end
        end
        chk("b2b_done_count", 32'(ndone), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
